// File: rtl/decode_thread_arbiter.sv
// Round-robin arbiter sharing one decode unit between hardware-thread fetch requesters.
// Optional macro DECODE_ARB_BURST_EN lets a requester keep priority for up to maxBurst grants.
// Per-requester vectors are MSB-first: requester 0 owns the MSB bit and MSB slice.
module decode_thread_arbiter #(
  parameter int unsigned numRequesters           = 4,
  parameter int unsigned reqIdxWidth             = 2,
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionWidth        = 32,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned maxBurst                = 4
) (
  input  logic                                          clock_i,
  input  logic                                          reset_i,
  input  logic                                          stall_i,
  input  logic [numRequesters-1:0]                      flushMask_i,
  input  logic [numRequesters-1:0]                      reqValid_i,
  input  logic [numRequesters*instructionWidth-1:0]     reqInstruction_i,
  input  logic [numRequesters*addressWidth-1:0]         reqAddress_i,
  input  logic [numRequesters-1:0]                      reqIs64Bit_i,
  input  logic [numRequesters*PidSize-1:0]              reqPid_i,
  input  logic [numRequesters*TidSize-1:0]              reqTid_i,
  output logic [numRequesters-1:0]                      reqAck_o,
  output logic                                          enable_o,
  output logic [instructionWidth-1:0]                   instruction_o,
  output logic [addressWidth-1:0]                       instructionAddress_o,
  output logic                                          is64Bit_o,
  output logic [PidSize-1:0]                            instructionPid_o,
  output logic [TidSize-1:0]                            instructionTid_o,
  output logic [instructionCounterWidth-1:0]            instructionMajId_o,
  output logic [reqIdxWidth-1:0]                        reqIdx_o
);

  localparam int unsigned N     = numRequesters;
  localparam int unsigned SLOTS = 1 << reqIdxWidth;
  localparam int unsigned IW    = instructionWidth;
  localparam int unsigned AW    = addressWidth;
  localparam int unsigned PW    = PidSize;
  localparam int unsigned TW    = TidSize;
  localparam int unsigned CW    = instructionCounterWidth;

  // Illegal configurations leave an unused marker signal that lint reports.
  if (N < 2 || N > 8 || SLOTS < N || maxBurst < 1) begin : g_bad_cfg
    logic cfg_unsupported;
  end

  logic [SLOTS-1:0]       valid_c, flush_c, elig_c;
  logic                   grant_c;
  logic [reqIdxWidth-1:0] grant_idx_c, cand_c, next_ptr_c;
  logic                   flush_held_c;

  logic [IW-1:0] sel_instr_c;
  logic [AW-1:0] sel_addr_c;
  logic          sel_is64_c;
  logic [PW-1:0] sel_pid_c;
  logic [TW-1:0] sel_tid_c;

  logic                   enable_q, enable_d;
  logic [IW-1:0]          instr_q, instr_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   is64_q, is64_d;
  logic [PW-1:0]          pid_q, pid_d;
  logic [TW-1:0]          tid_q, tid_d;
  logic [CW-1:0]          maj_id_q, maj_id_d;
  logic [CW-1:0]          maj_cnt_q, maj_cnt_d;
  logic [reqIdxWidth-1:0] idx_q, idx_d;
  logic [reqIdxWidth-1:0] rr_ptr_q, rr_ptr_d;

`ifdef DECODE_ARB_BURST_EN
  localparam int unsigned BW = $clog2(maxBurst + 1);
  logic [BW-1:0] burst_q, burst_d, burst_new_c;
`endif

  // Re-index the MSB-first request vectors so slot n is requester n.
  always_comb begin
    valid_c = '0;
    flush_c = '0;
    for (int n = 0; n < int'(N); n++) begin
      valid_c[n] = reqValid_i[int'(N) - 1 - n];
      flush_c[n] = flushMask_i[int'(N) - 1 - n];
    end
    elig_c = valid_c & ~flush_c;
  end

  // Search from the priority pointer, wrapping modulo the requester count.
  always_comb begin
    grant_c     = 1'b0;
    grant_idx_c = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_c = reqIdxWidth'((32'(rr_ptr_q) + i) % N);
      if (!grant_c && elig_c[cand_c]) begin
        grant_c     = 1'b1;
        grant_idx_c = cand_c;
      end
    end
    if (!reset_i || stall_i) begin
      grant_c = 1'b0;
    end
  end

  always_comb begin
    reqAck_o    = '0;
    sel_instr_c = '0;
    sel_addr_c  = '0;
    sel_is64_c  = 1'b0;
    sel_pid_c   = '0;
    sel_tid_c   = '0;
    for (int n = 0; n < int'(N); n++) begin
      reqAck_o[int'(N) - 1 - n] = grant_c && (grant_idx_c == reqIdxWidth'(n));
      if (grant_idx_c == reqIdxWidth'(n)) begin
        sel_instr_c = reqInstruction_i[(int'(N) - 1 - n) * int'(IW) +: IW];
        sel_addr_c  = reqAddress_i[(int'(N) - 1 - n) * int'(AW) +: AW];
        sel_is64_c  = reqIs64Bit_i[int'(N) - 1 - n];
        sel_pid_c   = reqPid_i[(int'(N) - 1 - n) * int'(PW) +: PW];
        sel_tid_c   = reqTid_i[(int'(N) - 1 - n) * int'(TW) +: TW];
      end
    end
  end

  assign flush_held_c = flush_c[idx_q];
  assign next_ptr_c   = (grant_idx_c == reqIdxWidth'(N - 1)) ? '0
                                                             : grant_idx_c + reqIdxWidth'(1);

  // Next state: stall freezes everything except a flush of the held instruction.
  always_comb begin
    enable_d  = enable_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    is64_d    = is64_q;
    pid_d     = pid_q;
    tid_d     = tid_q;
    maj_id_d  = maj_id_q;
    maj_cnt_d = maj_cnt_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
`ifdef DECODE_ARB_BURST_EN
    burst_d     = burst_q;
    burst_new_c = '0;
    if (flush_c[rr_ptr_q]) begin
      burst_d = '0;
    end
`endif
    if (stall_i) begin
      if (enable_q && flush_held_c) begin
        enable_d = 1'b0;
      end
    end else if (grant_c) begin
      enable_d  = 1'b1;
      instr_d   = sel_instr_c;
      addr_d    = sel_addr_c;
      is64_d    = sel_is64_c;
      pid_d     = sel_pid_c;
      tid_d     = sel_tid_c;
      idx_d     = grant_idx_c;
      maj_id_d  = maj_cnt_q;
      maj_cnt_d = maj_cnt_q + CW'(1);
`ifdef DECODE_ARB_BURST_EN
      burst_new_c = (grant_idx_c == rr_ptr_q) ? burst_q + BW'(1) : BW'(1);
      if (burst_new_c < BW'(maxBurst)) begin
        rr_ptr_d = grant_idx_c;
        burst_d  = burst_new_c;
      end else begin
        rr_ptr_d = next_ptr_c;
        burst_d  = '0;
      end
`else
      rr_ptr_d = next_ptr_c;
`endif
    end else begin
      enable_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      enable_q  <= 1'b0;
      instr_q   <= '0;
      addr_q    <= '0;
      is64_q    <= 1'b0;
      pid_q     <= '0;
      tid_q     <= '0;
      maj_id_q  <= '0;
      maj_cnt_q <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
`ifdef DECODE_ARB_BURST_EN
      burst_q   <= '0;
`endif
    end else begin
      enable_q  <= enable_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      is64_q    <= is64_d;
      pid_q     <= pid_d;
      tid_q     <= tid_d;
      maj_id_q  <= maj_id_d;
      maj_cnt_q <= maj_cnt_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
`ifdef DECODE_ARB_BURST_EN
      burst_q   <= burst_d;
`endif
    end
  end

  assign enable_o             = enable_q;
  assign instruction_o        = instr_q;
  assign instructionAddress_o = addr_q;
  assign is64Bit_o            = is64_q;
  assign instructionPid_o     = pid_q;
  assign instructionTid_o     = tid_q;
  assign instructionMajId_o   = maj_id_q;
  assign reqIdx_o             = idx_q;

endmodule

// File: tb/tb_decode_thread_arbiter.sv
// Directed self-checking bench for decode_thread_arbiter (4 requesters, default widths).
module tb_decode_thread_arbiter;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         stall_i;
  logic [3:0]   flushMask_i;
  logic [3:0]   reqValid_i;
  logic [127:0] reqInstruction_i;
  logic [255:0] reqAddress_i;
  logic [3:0]   reqIs64Bit_i;
  logic [79:0]  reqPid_i;
  logic [63:0]  reqTid_i;
  logic [3:0]   reqAck_o;
  logic         enable_o;
  logic [31:0]  instruction_o;
  logic [63:0]  instructionAddress_o;
  logic         is64Bit_o;
  logic [19:0]  instructionPid_o;
  logic [15:0]  instructionTid_o;
  logic [63:0]  instructionMajId_o;
  logic [1:0]   reqIdx_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_thread_arbiter dut (
    .clock_i              (clk),
    .reset_i              (reset_i),
    .stall_i              (stall_i),
    .flushMask_i          (flushMask_i),
    .reqValid_i           (reqValid_i),
    .reqInstruction_i     (reqInstruction_i),
    .reqAddress_i         (reqAddress_i),
    .reqIs64Bit_i         (reqIs64Bit_i),
    .reqPid_i             (reqPid_i),
    .reqTid_i             (reqTid_i),
    .reqAck_o             (reqAck_o),
    .enable_o             (enable_o),
    .instruction_o        (instruction_o),
    .instructionAddress_o (instructionAddress_o),
    .is64Bit_o            (is64Bit_o),
    .instructionPid_o     (instructionPid_o),
    .instructionTid_o     (instructionTid_o),
    .instructionMajId_o   (instructionMajId_o),
    .reqIdx_o             (reqIdx_o)
  );

  function automatic logic [31:0] f_instr(input int n);
    return 32'hA000_0000 + 32'(n);
  endfunction
  function automatic logic [63:0] f_addr(input int n);
    return 64'h0000_0000_1000_0000 + 64'(4 * n);
  endfunction
  function automatic logic [19:0] f_pid(input int n);
    return 20'h0_0100 + 20'(n);
  endfunction
  function automatic logic [15:0] f_tid(input int n);
    return 16'h00F0 + 16'(n);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then let combinational ack settle.
  task automatic drive(input logic rst, input logic stl, input logic [3:0] valid,
                       input logic [3:0] flush);
    @(negedge clk);
    reset_i     = rst;
    stall_i     = stl;
    reqValid_i  = valid;
    flushMask_i = flush;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic out_chk(input string tag, input logic en, input int idx, input logic [63:0] maj);
    chk({tag, ".enable"}, 64'(enable_o), 64'(en));
    chk({tag, ".majid"}, instructionMajId_o, maj);
    chk({tag, ".idx"}, 64'(reqIdx_o), 64'(idx));
  endtask

  task automatic data_chk(input string tag, input int n);
    chk({tag, ".instr"}, 64'(instruction_o), 64'(f_instr(n)));
    chk({tag, ".addr"}, instructionAddress_o, f_addr(n));
    chk({tag, ".pid"}, 64'(instructionPid_o), 64'(f_pid(n)));
    chk({tag, ".tid"}, 64'(instructionTid_o), 64'(f_tid(n)));
    chk({tag, ".is64"}, 64'(is64Bit_o), 64'(n % 2));
  endtask

  initial begin
    reset_i     = 1'b0;
    stall_i     = 1'b0;
    flushMask_i = 4'b0000;
    reqValid_i  = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      reqInstruction_i[(3 - n) * 32 +: 32] = f_instr(n);
      reqAddress_i[(3 - n) * 64 +: 64]     = f_addr(n);
      reqIs64Bit_i[3 - n]                  = 1'(n % 2);
      reqPid_i[(3 - n) * 20 +: 20]         = f_pid(n);
      reqTid_i[(3 - n) * 16 +: 16]         = f_tid(n);
    end

    // Reset held low with every requester valid: no ack, cleared outputs.
    drive(1'b0, 1'b0, 4'b1111, 4'b0000);
    chk("reset.ack", 64'(reqAck_o), 64'h0);
    edge_wait();
    out_chk("reset", 1'b0, 0, 64'd0);
    chk("reset.instr", 64'(instruction_o), 64'h0);
    drive(1'b0, 1'b0, 4'b1111, 4'b0000);
    chk("reset2.ack", 64'(reqAck_o), 64'h0);
    edge_wait();

`ifdef DECODE_ARB_BURST_EN
    // Burst: each requester keeps priority for four consecutive grants.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 4'b1111, 4'b0000);
      chk("burst.ack", 64'(reqAck_o), 64'(4'b1000 >> ((i / 4) % 4)));
      edge_wait();
      out_chk("burst", 1'b1, (i / 4) % 4, 64'(i));
    end
`else
    // Round-robin over all four requesters, major IDs 0..7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 4'b1111, 4'b0000);
      chk("rr.ack", 64'(reqAck_o), 64'(4'b1000 >> (i % 4)));
      edge_wait();
      out_chk("rr", 1'b1, i % 4, 64'(i));
      data_chk("rr", i % 4);
    end

    // Stall for three cycles: outputs frozen on requester 3 / ID 7.
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 1'b1, 4'b1111, 4'b0000);
      chk("stall.ack", 64'(reqAck_o), 64'h0);
      edge_wait();
      out_chk("stall", 1'b1, 3, 64'd7);
      data_chk("stall", 3);
    end
    drive(1'b1, 1'b0, 4'b1111, 4'b0000);
    chk("unstall.ack", 64'(reqAck_o), 64'(4'b1000));
    edge_wait();
    out_chk("unstall", 1'b1, 0, 64'd8);

    drive(1'b1, 1'b0, 4'b1111, 4'b0000);
    chk("pre1.ack", 64'(reqAck_o), 64'(4'b0100));
    edge_wait();
    out_chk("pre1", 1'b1, 1, 64'd9);
    drive(1'b1, 1'b0, 4'b1111, 4'b0000);
    chk("pre2.ack", 64'(reqAck_o), 64'(4'b0010));
    edge_wait();
    out_chk("pre2", 1'b1, 2, 64'd10);
    data_chk("pre2", 2);

    // Flush held requester 2 while stalled: enable drops, ID 10 becomes a gap.
    drive(1'b1, 1'b1, 4'b1111, 4'b0010);
    chk("flush.ack", 64'(reqAck_o), 64'h0);
    edge_wait();
    chk("flush.enable", 64'(enable_o), 64'h0);
    drive(1'b1, 1'b0, 4'b0100, 4'b0000);
    chk("postflush.ack", 64'(reqAck_o), 64'(4'b0100));
    edge_wait();
    out_chk("postflush", 1'b1, 1, 64'd11);
    data_chk("postflush", 1);

    // Flush of held requester 1 plus flushed requester 2 at the pointer: grant goes to 3.
    drive(1'b1, 1'b0, 4'b1111, 4'b0110);
    chk("flushgrant.ack", 64'(reqAck_o), 64'(4'b0001));
    edge_wait();
    out_chk("flushgrant", 1'b1, 3, 64'd12);

    drive(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk("idle.ack", 64'(reqAck_o), 64'h0);
    edge_wait();
    chk("idle.enable", 64'(enable_o), 64'h0);
    drive(1'b1, 1'b1, 4'b1111, 4'b0000);
    chk("idlestall.ack", 64'(reqAck_o), 64'h0);
    edge_wait();
    chk("idlestall.enable", 64'(enable_o), 64'h0);

    // Preload the major counter to all-ones during a stalled cycle.
    drive(1'b1, 1'b1, 4'b0000, 4'b0000);
    force dut.maj_cnt_d = '1;
    edge_wait();
    release dut.maj_cnt_d;
    chk("preload.enable", 64'(enable_o), 64'h0);
    drive(1'b1, 1'b0, 4'b1111, 4'b0000);
    chk("wrap1.ack", 64'(reqAck_o), 64'(4'b1000));
    edge_wait();
    out_chk("wrap1", 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, 1'b0, 4'b1111, 4'b0000);
    chk("wrap2.ack", 64'(reqAck_o), 64'(4'b0100));
    edge_wait();
    out_chk("wrap2", 1'b1, 1, 64'd0);

    // Reset mid-operation drops the held instruction and restarts from requester 0.
    drive(1'b0, 1'b0, 4'b1111, 4'b0000);
    chk("midreset.ack", 64'(reqAck_o), 64'h0);
    edge_wait();
    out_chk("midreset", 1'b0, 0, 64'd0);
    drive(1'b1, 1'b0, 4'b1111, 4'b0000);
    chk("afterreset.ack", 64'(reqAck_o), 64'(4'b1000));
    edge_wait();
    out_chk("afterreset", 1'b1, 0, 64'd0);
    data_chk("afterreset", 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
